sdcard_wr_sequencer: RTL and testbench



---
 rtl/sdcard_wr_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_sdcard_wr_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdcard_wr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sdcard_wr_sequencer                                           |
// | Function : Copies every scene picture from SD card into SDRAM once the   |
// |            card is initialised: requests sectors, streams returned words |
// |            into the SDRAM write FIFO and frames each picture slot.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sdcard_wr_sequencer #(
  parameter int          PHOTO_NUM     = 8,
  parameter int          PHOTO_WORDS   = 786432,
  parameter int          SEC_WORDS     = 256,
  parameter int          SEC_PER_PHOTO = 3072,
  parameter logic [31:0] SD_BASE_SEC   = 32'd16640,
  parameter int          MAX_RETRY     = 3
) (
  input  logic        hdmi_clk,
  input  logic        sys_rst_n,
  input  logic        sd_init_done,
  input  logic        sd_rd_busy,
  input  logic        sd_rd_data_valid,
  input  logic [15:0] sd_rd_data,
  input  logic        sdram_wr_full,
  input  logic        reload_req,
  output logic        sd_rd_start,
  output logic [31:0] sd_rd_sec_addr,
  output logic        sdram_wr_en,
  output logic [15:0] sdram_wr_data,
  output logic [22:0] sdram_wr_b_addr,
  output logic [22:0] sdram_wr_e_addr,
  output logic        sdram_wr_rst_n,
  output logic [2:0]  photo_idx,
  output logic        all_photo_en,
  output logic        load_err
);

  localparam int c_SEC_W   = (SEC_PER_PHOTO > 1) ? $clog2(SEC_PER_PHOTO) : 1;
  localparam int c_WORD_W  = $clog2(SEC_WORDS + 1);
  localparam int c_RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [22:0]          c_PHOTO_WORDS = 23'(PHOTO_WORDS);
  localparam logic [c_SEC_W-1:0]   c_SEC_LAST    = c_SEC_W'(SEC_PER_PHOTO - 1);
  localparam logic [c_WORD_W-1:0]  c_SEC_WORDS   = c_WORD_W'(SEC_WORDS);
  localparam logic [c_RETRY_W-1:0] c_RETRY_LAST  = c_RETRY_W'(MAX_RETRY - 1);
  localparam logic [2:0]           c_PHOTO_LAST  = 3'(PHOTO_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_REQ, S_WAIT_BUSY, S_XFER, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_photo_idx, w_photo_nxt;
  logic [c_SEC_W-1:0]    r_sec_cnt, w_sec_nxt;
  logic [c_RETRY_W-1:0]  r_retry_cnt, w_retry_nxt;
  logic [c_WORD_W-1:0]   r_word_cnt;
  logic                  w_short;
  logic                  w_abort;
  logic                  w_accept;
  logic [22:0]           w_b_addr_nxt;
  logic [31:0]           w_sec_addr_nxt;
  logic                  r_wr_en;
  logic [15:0]           r_wr_data;
  logic [22:0]           r_b_addr, r_e_addr;
  logic [31:0]           r_sec_addr;
  logic                  r_load_err;

  // Losing the card mid-load restarts from picture 0; DONE and ERR keep their result.
  assign w_abort = !sd_init_done && !(r_state inside {S_IDLE, S_DONE, S_ERR});

  // A word is taken while a sector is outstanding; words past a full sector are dropped.
  // REQ starts a fresh sector, so the stale count from the previous one is ignored there.
  assign w_accept = sd_rd_data_valid && !w_abort &&
                    ((r_state == S_REQ) ||
                     ((r_state inside {S_WAIT_BUSY, S_XFER}) && (r_word_cnt != c_SEC_WORDS)));

  assign w_b_addr_nxt   = 23'(w_photo_nxt) * c_PHOTO_WORDS;
  assign w_sec_addr_nxt = SD_BASE_SEC + 32'(w_photo_nxt) * 32'(SEC_PER_PHOTO) + 32'(w_sec_nxt);

  // Next-state and next-counter decode.
  always_comb begin
    w_state_nxt = r_state;
    w_photo_nxt = r_photo_idx;
    w_sec_nxt   = r_sec_cnt;
    w_retry_nxt = r_retry_cnt;
    w_short     = 1'b0;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_photo_nxt = 3'd0;
      w_sec_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE:      if (sd_init_done) w_state_nxt = S_ARM;
        S_ARM:       w_state_nxt = S_REQ;
        S_REQ:       w_state_nxt = S_WAIT_BUSY;
        S_WAIT_BUSY: if (sd_rd_busy) w_state_nxt = S_XFER;
        S_XFER:      if (!sd_rd_busy) w_state_nxt = S_CHECK;
        S_CHECK: begin
          if (r_word_cnt == c_SEC_WORDS) begin
            w_retry_nxt = '0;
            if (r_sec_cnt == c_SEC_LAST) begin
              w_sec_nxt = '0;
              if (r_photo_idx == c_PHOTO_LAST) begin
                w_state_nxt = S_DONE;
              end else begin
                w_photo_nxt = r_photo_idx + 3'd1;
                w_state_nxt = S_ARM;
              end
            end else begin
              w_sec_nxt   = r_sec_cnt + 1'b1;
              w_state_nxt = S_REQ;
            end
          end else begin
            // Short sector: the SDRAM pointer already advanced, so the data is suspect.
            w_short     = 1'b1;
            w_retry_nxt = r_retry_cnt + 1'b1;
            w_state_nxt = (r_retry_cnt == c_RETRY_LAST) ? S_ERR : S_REQ;
          end
        end
        S_DONE: begin
          if (reload_req) begin
            w_photo_nxt = 3'd0;
            w_state_nxt = S_ARM;
          end
        end
        S_ERR:   w_state_nxt = S_ERR;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and load-progress counters.
  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_photo_idx <= 3'd0;
      r_sec_cnt   <= '0;
      r_retry_cnt <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_photo_idx <= w_photo_nxt;
      r_sec_cnt   <= w_sec_nxt;
      r_retry_cnt <= w_retry_nxt;
      if (w_abort)
        r_word_cnt <= '0;
      else if (r_state == S_REQ)
        r_word_cnt <= c_WORD_W'(w_accept);
      else if (w_accept)
        r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  // Slot window and sector address are captured on entry so they are valid in ARM/REQ.
  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_b_addr   <= 23'd0;
      r_e_addr   <= c_PHOTO_WORDS - 23'd1;
      r_sec_addr <= 32'd0;
    end else begin
      if (w_state_nxt == S_ARM && r_state != S_ARM) begin
        r_b_addr <= w_b_addr_nxt;
        r_e_addr <= w_b_addr_nxt + c_PHOTO_WORDS - 23'd1;
      end
      if (w_state_nxt == S_REQ && r_state != S_REQ)
        r_sec_addr <= w_sec_addr_nxt;
    end
  end

  // One-cycle write pipeline from SD word strobe to SDRAM FIFO, plus sticky error.
  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_en    <= 1'b0;
      r_wr_data  <= 16'd0;
      r_load_err <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept)
        r_wr_data <= sd_rd_data;
      if (w_short || (r_wr_en && sdram_wr_full))
        r_load_err <= 1'b1;
    end
  end

  assign sd_rd_start     = (r_state == S_REQ);
  assign sdram_wr_rst_n  = (r_state != S_ARM);
  assign all_photo_en    = (r_state == S_DONE);
  assign sd_rd_sec_addr  = r_sec_addr;
  assign sdram_wr_en     = r_wr_en;
  assign sdram_wr_data   = r_wr_data;
  assign sdram_wr_b_addr = r_b_addr;
  assign sdram_wr_e_addr = r_e_addr;
  assign photo_idx       = r_photo_idx;
  assign load_err        = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_sdcard_wr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sdcard_wr_sequencer                                        |
// | Function : Self-checking bench: behavioural SD card responder and        |
// |            picture/sector model against sdcard_wr_sequencer.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sdcard_wr_sequencer;
  localparam int          PN   = 2;
  localparam int          PW   = 786432;
  localparam int          SW   = 256;
  localparam int          SPP  = 2;
  localparam int          MR   = 3;
  localparam logic [31:0] BASE = 32'd16640;

  logic        hdmi_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        sd_init_done = 1'b0;
  logic        sd_rd_busy = 1'b0;
  logic        sd_rd_data_valid = 1'b0;
  logic [15:0] sd_rd_data = 16'd0;
  logic        sdram_wr_full = 1'b0;
  logic        reload_req = 1'b0;
  logic        sd_rd_start;
  logic [31:0] sd_rd_sec_addr;
  logic        sdram_wr_en;
  logic [15:0] sdram_wr_data;
  logic [22:0] sdram_wr_b_addr;
  logic [22:0] sdram_wr_e_addr;
  logic        sdram_wr_rst_n;
  logic [2:0]  photo_idx;
  logic        all_photo_en;
  logic        load_err;

  int n_checks = 0;
  int n_err = 0;
  int sd_word_idx = 0;   // index of the word currently presented within its sector
  bit full_rand = 1'b0;
  bit m_err_retry = 1'b0;
  int n_writes = 0;
  int n_arm = 0;
  logic        pend_en;
  logic [15:0] pend_data;
  logic        m_err_full;

  always #5 hdmi_clk = ~hdmi_clk;

  sdcard_wr_sequencer #(
    .PHOTO_NUM(PN), .PHOTO_WORDS(PW), .SEC_WORDS(SW), .SEC_PER_PHOTO(SPP),
    .SD_BASE_SEC(BASE), .MAX_RETRY(MR)
  ) dut (
    .hdmi_clk(hdmi_clk), .sys_rst_n(sys_rst_n), .sd_init_done(sd_init_done),
    .sd_rd_busy(sd_rd_busy), .sd_rd_data_valid(sd_rd_data_valid), .sd_rd_data(sd_rd_data),
    .sdram_wr_full(sdram_wr_full), .reload_req(reload_req), .sd_rd_start(sd_rd_start),
    .sd_rd_sec_addr(sd_rd_sec_addr), .sdram_wr_en(sdram_wr_en), .sdram_wr_data(sdram_wr_data),
    .sdram_wr_b_addr(sdram_wr_b_addr), .sdram_wr_e_addr(sdram_wr_e_addr),
    .sdram_wr_rst_n(sdram_wr_rst_n), .photo_idx(photo_idx), .all_photo_en(all_photo_en),
    .load_err(load_err)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: every word the card returns with index below SW must be written one cycle later;
  // a write seen while the FIFO reports full poisons the load.
  always @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_en    <= 1'b0;
      pend_data  <= 16'd0;
      m_err_full <= 1'b0;
    end else begin
      if (pend_en && sdram_wr_full) m_err_full <= 1'b1;
      pend_en   <= sd_rd_data_valid && (sd_word_idx < SW);
      pend_data <= sd_rd_data;
    end
  end

  // Per-cycle comparison of the write port against the model.
  always @(negedge hdmi_clk) begin
    if (sys_rst_n) begin
      chk("wr_en", sdram_wr_en, pend_en);
      if (pend_en) chk("wr_data", sdram_wr_data, pend_data);
      if (sdram_wr_en === 1'b1) n_writes++;
      if (sdram_wr_rst_n === 1'b0) n_arm++;
    end
  end

  task automatic step();
    @(negedge hdmi_clk);
    if (full_rand) sdram_wr_full = ($urandom_range(0, 63) == 0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0; sd_init_done = 1'b0; sd_rd_busy = 1'b0; sd_rd_data_valid = 1'b0;
    sd_rd_data = 16'd0; sdram_wr_full = 1'b0; reload_req = 1'b0; sd_word_idx = 0;
    full_rand = 1'b0; m_err_retry = 1'b0;
    repeat (3) @(negedge hdmi_clk);
    chk("rst_rd_start", sd_rd_start, 0);
    chk("rst_sec_addr", sd_rd_sec_addr, 0);
    chk("rst_wr_en", sdram_wr_en, 0);
    chk("rst_wr_data", sdram_wr_data, 0);
    chk("rst_b_addr", sdram_wr_b_addr, 0);
    chk("rst_e_addr", sdram_wr_e_addr, PW - 1);
    chk("rst_wr_rst_n", sdram_wr_rst_n, 1);
    chk("rst_photo_idx", photo_idx, 0);
    chk("rst_all_en", all_photo_en, 0);
    chk("rst_load_err", load_err, 0);
    sys_rst_n = 1'b1;
    @(negedge hdmi_clk);
  endtask

  // Picture p's slot is framed by a one-cycle FIFO re-arm, immediately followed by a request.
  task automatic wait_arm(input int p);
    int n = 0;
    while (sdram_wr_rst_n !== 1'b0 && n < 300) begin @(negedge hdmi_clk); n++; end
    chk("arm_seen", n < 300, 1);
    chk("arm_b_addr", sdram_wr_b_addr, p * PW);
    chk("arm_e_addr", sdram_wr_e_addr, p * PW + PW - 1);
    chk("arm_photo_idx", photo_idx, p);
    @(negedge hdmi_clk);
    chk("arm_width", sdram_wr_rst_n, 1);
    chk("req_after_arm", sd_rd_start, 1);
  endtask

  task automatic wait_req(input int p, input int s);
    int n = 0;
    while (sd_rd_start !== 1'b1 && n < 3000) begin @(negedge hdmi_clk); n++; end
    chk("req_seen", n < 3000, 1);
    chk("req_sec_addr", sd_rd_sec_addr, BASE + p * SPP + s);
    chk("req_photo_idx", photo_idx, p);
    chk("req_b_addr", sdram_wr_b_addr, p * PW);
  endtask

  // Card responder: random busy latency, nwords strobes with random gaps. Words from k0.
  // abort_after >= 0 drops the card (init and busy) after that many words.
  task automatic serve(input int k0, input int nwords, input int abort_after);
    if (k0 == 0) begin
      repeat ($urandom_range(0, 3)) step();
      sd_rd_busy = 1'b1;
    end
    for (int k = k0; k < nwords; k++) begin
      if (k == abort_after) begin
        sd_init_done = 1'b0; sd_rd_busy = 1'b0; sd_rd_data_valid = 1'b0;
        return;
      end
      sd_rd_data_valid = 1'b1; sd_rd_data = 16'($urandom); sd_word_idx = k;
      step();
      sd_rd_data_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    sd_rd_busy = 1'b0;
    step();
  endtask

  task automatic wait_done();
    int n = 0;
    while (all_photo_en !== 1'b1 && n < 300) begin @(negedge hdmi_clk); n++; end
    chk("done_seen", n < 300, 1);
  endtask

  task automatic count_starts(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin step(); if (sd_rd_start === 1'b1) cnt++; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, a0, cnt;

    // Full load of both pictures with a hand-checked first word.
    do_reset();
    w0 = n_writes; a0 = n_arm;
    sd_init_done = 1'b1;
    for (int p = 0; p < PN; p++) begin
      wait_arm(p);
      for (int s = 0; s < SPP; s++) begin
        wait_req(p, s);
        if (p == 0 && s == 0) begin
          sd_rd_busy = 1'b1; sd_rd_data_valid = 1'b1; sd_rd_data = 16'h1234; sd_word_idx = 0;
          step();
          sd_rd_data_valid = 1'b0;
          chk("lit_wr_en", sdram_wr_en, 1);
          chk("lit_wr_data", sdram_wr_data, 16'h1234);
          step();
          chk("lit_wr_en_off", sdram_wr_en, 0);
          serve(1, SW, -1);
        end else begin
          serve(0, SW, -1);
        end
      end
    end
    wait_done();
    chk("load1_writes", n_writes - w0, 1024);
    chk("load1_arms", n_arm - a0, 2);
    chk("load1_err", load_err, 0);
    chk("done_photo_idx", photo_idx, PN - 1);

    // Reload from DONE, with an overlong sector and random FIFO-full.
    w0 = n_writes;
    reload_req = 1'b1;
    step();
    reload_req = 1'b0;
    chk("reload_all_en", all_photo_en, 0);
    chk("reload_photo_idx", photo_idx, 0);
    chk("reload_arm", sdram_wr_rst_n, 0);
    chk("reload_b_addr", sdram_wr_b_addr, 0);
    full_rand = 1'b1;
    for (int p = 0; p < PN; p++) begin
      if (p > 0) wait_arm(p);
      for (int s = 0; s < SPP; s++) begin
        wait_req(p, s);
        serve(0, (p == 0 && s == 0) ? SW + 1 : SW, -1);
      end
    end
    full_rand = 1'b0; sdram_wr_full = 1'b0;
    wait_done();
    chk("load2_writes", n_writes - w0, 1024);
    chk("load2_err", load_err, m_err_full);

    // Short sectors: one retry then success, then three in a row end in ERR.
    do_reset();
    sd_init_done = 1'b1;
    wait_arm(0);
    wait_req(0, 0);
    serve(0, SW - 1, -1);
    m_err_retry = 1'b1;
    wait_req(0, 0);
    chk("retry_err", load_err, m_err_retry);
    serve(0, SW, -1);
    for (int r = 0; r < MR; r++) begin
      wait_req(0, 1);
      serve(0, SW - 1, -1);
    end
    reload_req = 1'b1;
    step();
    reload_req = 1'b0;
    count_starts(40, cnt);
    chk("err_no_req", cnt, 0);
    chk("err_all_en", all_photo_en, 0);
    chk("err_load_err", load_err, 1);

    // Card lost mid-transfer of picture 1, then restored.
    do_reset();
    sd_init_done = 1'b1;
    wait_arm(0);
    wait_req(0, 0); serve(0, SW, -1);
    wait_req(0, 1); serve(0, SW, -1);
    wait_arm(1);
    wait_req(1, 0); serve(0, SW, 100);
    count_starts(20, cnt);
    chk("abort_no_req", cnt, 0);
    chk("abort_photo_idx", photo_idx, 0);
    chk("abort_all_en", all_photo_en, 0);
    sd_init_done = 1'b1;
    wait_arm(0);
    wait_req(0, 0);

    repeat (3) @(negedge hdmi_clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
